// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared state and step encodings for the cl_* sequencers
package cl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } cl_state_e;

    // Partial-product order: low*low, low*high, high*low, high*high.
    typedef enum logic [1:0] {
        STEP_LL = 2'd0,
        STEP_LH = 2'd1,
        STEP_HL = 2'd2,
        STEP_HH = 2'd3
    } cl_step_e;

endpackage

// File: rtl/cl_half_mult.sv
// rtl/cl_half_mult.sv - combinational HxH carry-less multiply, 2H-bit product
module cl_half_mult #(
    parameter int H = 16
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < H; i++) begin
            if (b[i]) begin
                p = p ^ ({{H{1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/cl_mult_sequencer.sv
// rtl/cl_mult_sequencer.sv - four-pass carry-less multiplier around one half-width core
module cl_mult_sequencer
    import cl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_result,
    output logic                    busy
);

    localparam int H  = DATA_WIDTH / 2;
    localparam int PW = 2 * DATA_WIDTH;

    cl_state_e             state_q, state_d;
    cl_step_e              step_q, step_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [PW-1:0]         acc_q, acc_d;

    logic [H-1:0]   core_a;
    logic [H-1:0]   core_b;
    logic [2*H-1:0] core_p;
    logic [PW-1:0]  core_ext;
    logic [PW-1:0]  partial;

    cl_half_mult #(.H(H)) u_half_mult (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    // Operand half selection and placement of the partial product.
    always_comb begin
        core_a   = op_a_q[H-1:0];
        core_b   = op_b_q[H-1:0];
        core_ext = {{DATA_WIDTH{1'b0}}, core_p};
        partial  = core_ext;
        case (step_q)
            STEP_LH: begin
                core_b  = op_b_q[DATA_WIDTH-1:H];
                partial = core_ext << H;
            end
            STEP_HL: begin
                core_a  = op_a_q[DATA_WIDTH-1:H];
                partial = core_ext << H;
            end
            STEP_HH: begin
                core_a  = op_a_q[DATA_WIDTH-1:H];
                core_b  = op_b_q[DATA_WIDTH-1:H];
                partial = core_ext << DATA_WIDTH;
            end
            default: begin
                partial = core_ext;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    acc_d   = '0;
                    step_d  = STEP_LL;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d  = acc_q ^ partial;
                step_d = cl_step_e'(step_q + 2'd1);
                if (step_q == STEP_HH) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_LL;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_MUL) || (state_q == ST_DONE);
    assign out_result = acc_q;

endmodule

// File: tb/tb_cl_mult_sequencer.sv
// tb/tb_cl_mult_sequencer.sv - self-checking bench for cl_mult_sequencer
module tb_cl_mult_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_result8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0] in_a32, in_b32;
    logic [63:0] out_result32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cl_mult_sequencer #(.DATA_WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .in_a       (in_a8),
        .in_b       (in_b8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .out_result (out_result8),
        .busy       (busy8)
    );

    cl_mult_sequencer #(.DATA_WIDTH(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid32),
        .in_ready   (in_ready32),
        .in_a       (in_a32),
        .in_b       (in_b32),
        .out_valid  (out_valid32),
        .out_ready  (out_ready32),
        .out_result (out_result32),
        .busy       (busy32)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Schoolbook polynomial product: XOR in a shifted copy of a for every set bit of b.
    function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) r = r ^ ({32'd0, a} << i);
        end
        return r;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string name);
        @(negedge clk);
        check({name, "_in_ready_idle"}, in_ready8, 1);
        in_valid8  = 1'b1;
        in_a8      = a;
        in_b8      = b;
        out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        check({name, "_busy"}, busy8, 1);
        check({name, "_in_ready_mul"}, in_ready8, 0);
        for (int k = 0; k < 4; k++) begin
            check({name, "_valid_early"}, out_valid8, 0);
            @(negedge clk);
        end
        check({name, "_valid_at_5"}, out_valid8, 1);
        check({name, "_in_ready_done"}, in_ready8, 0);
        check({name, "_result"}, out_result8, exp);
        @(negedge clk);
        check({name, "_in_ready_after"}, in_ready8, 1);
        check({name, "_valid_after"}, out_valid8, 0);
    endtask

    logic [63:0] exp_q[$];
    logic [63:0] held_result;
    logic        was_stalled;
    int          issued, got, cycles;

    initial begin
        vecs[0] = '{8'h03, 8'h03, 16'h0005, "v03x03"};
        vecs[1] = '{8'hFF, 8'hFF, 16'h5555, "vFFxFF"};
        vecs[2] = '{8'h80, 8'h80, 16'h4000, "v80x80"};
        vecs[3] = '{8'h00, 8'hA5, 16'h0000, "v00xA5"};
        vecs[4] = '{8'h03, 8'h05, 16'h000F, "v03x05"};

        in_valid8 = 0; in_a8 = 0; in_b8 = 0; out_ready8 = 0;
        in_valid32 = 0; in_a32 = 0; in_b32 = 0; out_ready32 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_busy", busy8, 0);
        check("rst_result", out_result8, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Backpressure: hold DONE for three cycles while new requests are offered.
        @(negedge clk);
        in_valid8 = 1'b1; in_a8 = 8'h03; in_b8 = 8'h05; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", out_valid8, 1);
            check("bp_in_ready", in_ready8, 0);
            check("bp_result", out_result8, 16'h000F);
            in_valid8 = 1'b1;
            in_a8 = 8'($urandom);
            in_b8 = 8'($urandom);
            @(negedge clk);
        end
        check("bp_valid_4th", out_valid8, 1);
        check("bp_result_4th", out_result8, 16'h000F);
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        check("bp_released", in_ready8, 1);
        check("bp_no_accept", busy8, 0);

        // Reset while the step counter is at HL.
        in_valid8 = 1'b1; in_a8 = 8'hFF; in_b8 = 8'hFF;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", out_valid8, 0);
        check("rstmid_busy", busy8, 0);
        check("rstmid_in_ready", in_ready8, 1);
        check("rstmid_result", out_result8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h03, 8'h05, 16'h000F, "after_rst");

        // Operands scrambled every cycle after accept must not affect the result.
        @(negedge clk);
        in_valid8 = 1'b1; in_a8 = 8'hB7; in_b8 = 8'h5D; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_a8 = 8'($urandom);
            in_b8 = 8'($urandom);
            @(negedge clk);
        end
        check("iso_valid", out_valid8, 1);
        check("iso_result", out_result8, clmul_ref(32'hB7, 32'h5D, 8));
        @(negedge clk);

        // Random back-to-back traffic on the 32-bit instance.
        issued = 0; got = 0; cycles = 0; was_stalled = 0; held_result = '0;
        while ((got < 10000) && (cycles < 90000)) begin
            @(negedge clk);
            cycles++;
            if (in_ready32 && out_valid32) begin
                errors++;
                $display("FAIL rand_ready_valid_overlap at cycle %0d", cycles);
            end
            if (was_stalled) begin
                check("rand_hold_valid", out_valid32, 1);
                check("rand_hold_result", out_result32, held_result);
            end
            in_valid32  = (issued < 10000);
            in_a32      = $urandom;
            in_b32      = $urandom;
            out_ready32 = ($urandom_range(3) != 0);
            if (in_valid32 && in_ready32) begin
                exp_q.push_back(clmul_ref(in_a32, in_b32, 32));
                issued++;
            end
            if (out_valid32 && out_ready32) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_result: got 0x%0h expected none", out_result32);
                end else begin
                    check("rand_result", out_result32, exp_q.pop_front());
                end
                got++;
            end
            was_stalled = out_valid32 && !out_ready32;
            held_result = out_result32;
        end
        in_valid32 = 1'b0;
        check("rand_results_seen", got, 10000);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
